// File: rtl/fir_buf_pkg.sv
// Shared defaults, sample type and ring-index helper for the FIR sample ring.
package fir_buf_pkg;

  localparam int unsigned DEF_W    = 12;
  localparam int unsigned DEF_ADDR = 8;
  localparam int unsigned DEF_N    = 256;

  typedef logic [DEF_W-1:0] sample_t;

  // Ring slot of tap k; caller truncates to its pointer width for the mod-N wrap.
  function automatic logic [31:0] tap_index(input logic [31:0] wr_ptr, input logic [31:0] k);
    return wr_ptr - 32'd1 - k;
  endfunction

endpackage

// File: rtl/fir_sample_ring_if.sv
// Write/read/clear bus between the FIR MAC sequencer and the sample ring.
interface fir_sample_ring_if #(
  parameter int unsigned W      = 12,
  parameter int unsigned ADDR   = 8,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CH_W   = 1
) ();

  logic              clear_in;
  logic              wr_in;
  logic [CH_W-1:0]   wr_ch_in;
  logic [W-1:0]      x_in;
  logic              rd_in;
  logic [CH_W-1:0]   rd_ch_in;
  logic [ADDR-1:0]   addr_in;
  logic [W-1:0]      x_out;
  logic              rd_valid_out;
  logic [NUM_CH-1:0] full_out;

  modport master (
    output clear_in, wr_in, wr_ch_in, x_in, rd_in, rd_ch_in, addr_in,
    input  x_out, rd_valid_out, full_out
  );

  modport slave (
    input  clear_in, wr_in, wr_ch_in, x_in, rd_in, rd_ch_in, addr_in,
    output x_out, rd_valid_out, full_out
  );

endinterface

// File: rtl/fir_ring_ram.sv
// Simple dual-port sample RAM with registered, read-old-data output port.
module fir_ring_ram #(
  parameter int unsigned W     = 12,
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic          rd_zero,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (we) mem[waddr] <= wdata;
  end

  // Zero-forcing of unfilled taps is folded into the output register.
  always_ff @(posedge clk_in) begin
    if (rst_in)  rdata <= '0;
    else if (re) rdata <= rd_zero ? '0 : mem[raddr];
  end

endmodule

// File: rtl/fir_sample_ring.sv
// Multi-channel circular FIR delay line: per-channel write pointer and fill count over a shared RAM.
module fir_sample_ring
  import fir_buf_pkg::*;
#(
  parameter int unsigned W      = DEF_W,
  parameter int unsigned ADDR   = DEF_ADDR,
  parameter int unsigned N      = DEF_N,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk_in,
  input  logic               rst_in,
  fir_sample_ring_if.slave   bus
);

  localparam int unsigned DEPTH  = NUM_CH * N;
  localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR:0] FILL_MAX = (ADDR+1)'(N);

  logic [ADDR-1:0]   wr_ptr_q [NUM_CH];
  logic [ADDR:0]     fill_q   [NUM_CH];
  logic [NUM_CH-1:0] full_q;
  logic              rd_valid_q;

  logic              wr_ch_ok_c, rd_ch_ok_c, wr_en_c, rd_zero_c;
  logic [CH_W-1:0]   wc_c, rc_c;
  logic [ADDR-1:0]   tap_c;
  logic [RAM_AW-1:0] waddr_c, raddr_c;
  logic [W-1:0]      ram_rdata;

  // Channel range checks and physical address generation from pre-write state.
  always_comb begin
    wr_ch_ok_c = 32'(bus.wr_ch_in) < NUM_CH;
    rd_ch_ok_c = 32'(bus.rd_ch_in) < NUM_CH;
    wc_c       = wr_ch_ok_c ? bus.wr_ch_in : '0;
    rc_c       = rd_ch_ok_c ? bus.rd_ch_in : '0;
    wr_en_c    = bus.wr_in && wr_ch_ok_c && !bus.clear_in && !rst_in;
    waddr_c    = RAM_AW'(32'(wc_c) * N + 32'(wr_ptr_q[wc_c]));
    tap_c      = ADDR'(tap_index(32'(wr_ptr_q[rc_c]), 32'(bus.addr_in)));
    raddr_c    = RAM_AW'(32'(rc_c) * N + 32'(tap_c));
    rd_zero_c  = !rd_ch_ok_c || ({1'b0, bus.addr_in} >= fill_q[rc_c]);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || bus.clear_in) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        wr_ptr_q[c] <= '0;
        fill_q[c]   <= '0;
      end
      full_q <= '0;
    end else if (wr_en_c) begin
      wr_ptr_q[wc_c] <= wr_ptr_q[wc_c] + ADDR'(1);
      if (fill_q[wc_c] != FILL_MAX) fill_q[wc_c] <= fill_q[wc_c] + (ADDR+1)'(1);
      if (fill_q[wc_c] == FILL_MAX - (ADDR+1)'(1)) full_q[wc_c] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) rd_valid_q <= 1'b0;
    else        rd_valid_q <= bus.rd_in;
  end

  fir_ring_ram #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (RAM_AW)
  ) u_ram (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .we      (wr_en_c),
    .waddr   (waddr_c),
    .wdata   (bus.x_in),
    .re      (bus.rd_in),
    .rd_zero (rd_zero_c),
    .raddr   (raddr_c),
    .rdata   (ram_rdata)
  );

  assign bus.x_out        = ram_rdata;
  assign bus.rd_valid_out = rd_valid_q;
  assign bus.full_out     = full_q;

endmodule

// File: tb/tb_fir_sample_ring.sv
// Directed bench for fir_sample_ring: fill masking, wrap, read-before-write, clear and reset.
module tb_fir_sample_ring;
  import fir_buf_pkg::*;

  localparam int unsigned N = 256;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  fir_sample_ring_if #(.W(12), .ADDR(8), .NUM_CH(2), .CH_W(1)) bus ();

  fir_sample_ring #(.W(12), .ADDR(8), .N(256), .NUM_CH(2), .CH_W(1)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle;
    bus.clear_in = 1'b0;
    bus.wr_in    = 1'b0;
    bus.rd_in    = 1'b0;
  endtask

  task automatic write(input logic ch, input sample_t x);
    bus.wr_in = 1'b1; bus.wr_ch_in = ch; bus.x_in = x;
    tick();
    bus.wr_in = 1'b0;
  endtask

  task automatic read(input logic ch, input logic [7:0] k);
    bus.rd_in = 1'b1; bus.rd_ch_in = ch; bus.addr_in = k;
    tick();
    bus.rd_in = 1'b0;
  endtask

  task automatic test_reset;
    rst_in = 1'b1; idle(); bus.wr_ch_in = '0; bus.x_in = '0; bus.rd_ch_in = '0; bus.addr_in = '0;
    tick(); tick();
    n_checks++; if (bus.x_out !== 12'h000) begin n_fail++; $display("FAIL reset_x_out got %h want 000", bus.x_out); end
    n_checks++; if (bus.rd_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.rd_valid_out); end
    n_checks++; if (bus.full_out !== 2'b00) begin n_fail++; $display("FAIL reset_full got %b want 00", bus.full_out); end
    rst_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      read(1'b0, 8'(k));
      n_checks++; if (bus.x_out !== 12'h000) begin n_fail++; $display("FAIL empty_read k=%0d got %h want 000", k, bus.x_out); end
      n_checks++; if (bus.rd_valid_out !== 1'b1) begin n_fail++; $display("FAIL empty_valid k=%0d got %b want 1", k, bus.rd_valid_out); end
    end
    tick();
    n_checks++; if (bus.rd_valid_out !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b want 0", bus.rd_valid_out); end
    n_checks++; if (bus.full_out !== 2'b00) begin n_fail++; $display("FAIL empty_full got %b want 00", bus.full_out); end
  endtask

  task automatic test_write_read;
    for (int i = 1; i <= 5; i++) write(1'b0, 12'(i));
    for (int k = 0; k < 5; k++) begin
      read(1'b0, 8'(k));
      n_checks++; if (bus.x_out !== 12'(5 - k)) begin n_fail++; $display("FAIL tap_read k=%0d got %h want %h", k, bus.x_out, 12'(5 - k)); end
    end
    read(1'b0, 8'd5);
    n_checks++; if (bus.x_out !== 12'h000) begin n_fail++; $display("FAIL tap_masked k=5 got %h want 000", bus.x_out); end
    read(1'b0, 8'd0);
    tick();
    n_checks++; if (bus.x_out !== 12'h005) begin n_fail++; $display("FAIL hold_x_out got %h want 005", bus.x_out); end
    n_checks++; if (bus.rd_valid_out !== 1'b0) begin n_fail++; $display("FAIL hold_valid got %b want 0", bus.rd_valid_out); end
  endtask

  task automatic test_fill_wrap;
    for (int i = 0; i < int'(N) + 3; i++) begin
      write(1'b1, 12'(i));
      if (i == int'(N) - 2) begin
        n_checks++; if (bus.full_out[1] !== 1'b0) begin n_fail++; $display("FAIL full_early got %b want 0", bus.full_out[1]); end
      end
      if (i == int'(N) - 1) begin
        n_checks++; if (bus.full_out[1] !== 1'b1) begin n_fail++; $display("FAIL full_rise got %b want 1", bus.full_out[1]); end
      end
    end
    read(1'b1, 8'd0);
    n_checks++; if (bus.x_out !== 12'h102) begin n_fail++; $display("FAIL wrap_newest got %h want 102", bus.x_out); end
    read(1'b1, 8'd255);
    n_checks++; if (bus.x_out !== 12'h003) begin n_fail++; $display("FAIL wrap_oldest got %h want 003", bus.x_out); end
    read(1'b0, 8'd0);
    n_checks++; if (bus.x_out !== 12'h005) begin n_fail++; $display("FAIL ch0_isolated got %h want 005", bus.x_out); end
    n_checks++; if (bus.full_out[0] !== 1'b0) begin n_fail++; $display("FAIL ch0_full got %b want 0", bus.full_out[0]); end
  endtask

  task automatic test_read_before_write;
    for (int i = 6; i <= 256; i++) write(1'b0, 12'(i));
    n_checks++; if (bus.full_out !== 2'b11) begin n_fail++; $display("FAIL both_full got %b want 11", bus.full_out); end
    bus.rd_in = 1'b1; bus.rd_ch_in = 1'b0; bus.addr_in = 8'd255;
    bus.wr_in = 1'b1; bus.wr_ch_in = 1'b0; bus.x_in = 12'hABC;
    tick(); idle();
    n_checks++; if (bus.x_out !== 12'h001) begin n_fail++; $display("FAIL rbw_old got %h want 001", bus.x_out); end
    n_checks++; if (bus.rd_valid_out !== 1'b1) begin n_fail++; $display("FAIL rbw_valid got %b want 1", bus.rd_valid_out); end
    read(1'b0, 8'd0);
    n_checks++; if (bus.x_out !== 12'hABC) begin n_fail++; $display("FAIL rbw_new got %h want abc", bus.x_out); end
    read(1'b0, 8'd255);
    n_checks++; if (bus.x_out !== 12'h002) begin n_fail++; $display("FAIL rbw_oldest got %h want 002", bus.x_out); end
  endtask

  task automatic test_independent_channels;
    bus.rd_in = 1'b1; bus.rd_ch_in = 1'b0; bus.addr_in = 8'd1;
    bus.wr_in = 1'b1; bus.wr_ch_in = 1'b1; bus.x_in = 12'h123;
    tick(); idle();
    n_checks++; if (bus.x_out !== 12'h100) begin n_fail++; $display("FAIL xch_read got %h want 100", bus.x_out); end
    read(1'b1, 8'd0);
    n_checks++; if (bus.x_out !== 12'h123) begin n_fail++; $display("FAIL xch_write got %h want 123", bus.x_out); end
    read(1'b1, 8'd1);
    n_checks++; if (bus.x_out !== 12'h102) begin n_fail++; $display("FAIL xch_prev got %h want 102", bus.x_out); end
  endtask

  task automatic test_clear;
    bus.clear_in = 1'b1;
    bus.wr_in = 1'b1; bus.wr_ch_in = 1'b0; bus.x_in = 12'h777;
    bus.rd_in = 1'b1; bus.rd_ch_in = 1'b0; bus.addr_in = 8'd0;
    tick(); idle();
    n_checks++; if (bus.full_out !== 2'b00) begin n_fail++; $display("FAIL clear_full got %b want 00", bus.full_out); end
    n_checks++; if (bus.x_out !== 12'hABC) begin n_fail++; $display("FAIL clear_preread got %h want abc", bus.x_out); end
    read(1'b0, 8'd0);
    n_checks++; if (bus.x_out !== 12'h000) begin n_fail++; $display("FAIL clear_ch0 got %h want 000", bus.x_out); end
    read(1'b1, 8'd0);
    n_checks++; if (bus.x_out !== 12'h000) begin n_fail++; $display("FAIL clear_ch1 got %h want 000", bus.x_out); end
    write(1'b0, 12'h042);
    read(1'b0, 8'd0);
    n_checks++; if (bus.x_out !== 12'h042) begin n_fail++; $display("FAIL post_clear_new got %h want 042", bus.x_out); end
    read(1'b0, 8'd1);
    n_checks++; if (bus.x_out !== 12'h000) begin n_fail++; $display("FAIL dropped_write got %h want 000", bus.x_out); end
  endtask

  task automatic test_back_to_back;
    logic [11:0] exp_q [4] = '{12'h0D4, 12'h0C3, 12'h0B2, 12'h0A1};
    write(1'b1, 12'h0A1); write(1'b1, 12'h0B2); write(1'b1, 12'h0C3); write(1'b1, 12'h0D4);
    bus.rd_in = 1'b1; bus.rd_ch_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.addr_in = 8'(k);
      tick();
      n_checks++; if (bus.x_out !== exp_q[k] || bus.rd_valid_out !== 1'b1) begin
        n_fail++; $display("FAIL b2b k=%0d got %h/%b want %h/1", k, bus.x_out, bus.rd_valid_out, exp_q[k]);
      end
    end
    idle();
  endtask

  task automatic test_reset_inflight;
    read(1'b1, 8'd0);
    n_checks++; if (bus.x_out !== 12'h0D4) begin n_fail++; $display("FAIL pre_reset got %h want 0d4", bus.x_out); end
    rst_in = 1'b1;
    bus.rd_in = 1'b1; bus.rd_ch_in = 1'b1; bus.addr_in = 8'd0;
    tick(); idle(); rst_in = 1'b0;
    n_checks++; if (bus.rd_valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", bus.rd_valid_out); end
    n_checks++; if (bus.x_out !== 12'h000) begin n_fail++; $display("FAIL rst_x_out got %h want 000", bus.x_out); end
    tick();
    n_checks++; if (bus.rd_valid_out !== 1'b0 || bus.x_out !== 12'h000) begin
      n_fail++; $display("FAIL rst_after got %h/%b want 000/0", bus.x_out, bus.rd_valid_out);
    end
    n_checks++; if (bus.full_out !== 2'b00) begin n_fail++; $display("FAIL rst_full got %b want 00", bus.full_out); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_fill_wrap();
    test_read_before_write();
    test_independent_channels();
    test_clear();
    test_back_to_back();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_sample_ring.md
# fir_sample_ring

Parametrised, multi-channel circular sample buffer. It is the next generation of the FIR tap delay line. Each channel keeps its last N samples in a RAM ring addressed by a write pointer, so no shift register is used. The FIR MAC sequencer reads any tap (k = 0 is the newest sample) with a fixed 1-cycle latency. Taps older than the number of samples written since reset or clear read as zero, which matches a zero-initialised delay line.

## Interface
- `W`, default 12: sample width in bits.
- `ADDR`, default 8: tap index width.
- `N`, default 256: taps per channel. Must equal 2**ADDR.
- `NUM_CH`, default 2: number of channels. Must be ≥1.
- `CH_W`, default `$clog2(NUM_CH)`, minimum 1: channel select width.
- `clk_in`, input, 1: single clock. All logic is on the rising edge.
- `rst_in`, input, 1: reset, synchronous and active-high.
- `clear_in`, input, 1: synchronous flush of all channels' fill counts and write pointers. RAM contents are not touched.
- `wr_in`, input, 1: write strobe, 1-cycle qualified. Pushes `x_in` into channel `wr_ch_in`.
- `wr_ch_in`, input, CH_W: write channel.
- `x_in`, input, W: sample to write.
- `rd_in`, input, 1: read request, 1-cycle qualified.
- `rd_ch_in`, input, CH_W: read channel.
- `addr_in`, input, ADDR: tap index k. 0 is the newest sample, N-1 the oldest.
- `x_out`, output, W: registered tap data.
- `rd_valid_out`, output, 1: `x_out` is valid this cycle.
- `full_out`, output, NUM_CH: bit c is high once channel c holds N samples.

## Operation
- Per-channel state: `wr_ptr[c]` (ADDR bits) and `fill[c]` (ADDR+1 bits, saturates at N).
- Write (`wr_in`=1):
  - `ram[c*N + wr_ptr[c]] <= x_in`.
  - `wr_ptr[c]` increments modulo N. Wrap from N-1 to 0 is silent.
  - `fill[c]` increments, saturating at N.
- Read (`rd_in`=1):
  - Physical index is `c*N + ((wr_ptr[c] - 1 - k) mod N)`.
  - If k ≥ `fill[c]`, the result is forced to 0. The mask is registered alongside the RAM read.
- `wr_ch_in` or `rd_ch_in` ≥ NUM_CH: the request is ignored. A read still asserts `rd_valid_out` with `x_out`=0.
- Simultaneous write and read, same channel: the read sees pre-write state (pointer, fill and RAM).
  - The case k = N-1 with `fill`=N hits the slot being written. It must return the old oldest sample (read-before-write).
- Simultaneous writes/reads on different channels: fully independent.
- Clear: `wr_ptr` and `fill` of all channels go to 0 and `full_out` goes to 0. A write in the same cycle as `clear_in` is dropped. A read in the same cycle as `clear_in` returns pre-clear data.
- Reset: same effect as clear, plus `x_out`=0 and `rd_valid_out`=0. A read in flight is discarded.
- Arithmetic: pointer math is unsigned ADDR-bit with natural wrap. No sign handling on data; samples pass through bit-exact.

## Timing
- Read latency is 1 cycle. A request at edge t gives `x_out` and `rd_valid_out`=1 after edge t+1. Back-to-back reads give one result per cycle.
- `x_out` holds its last value when `rd_valid_out`=0.
- A write at edge t is visible to a read issued at edge t+1, as k=0.
- `full_out[c]` rises at the edge that performs the Nth write after reset or clear.
- Reset values: `x_out`=0, `rd_valid_out`=0, `full_out`=0.

## Structure
- Package `fir_buf_pkg`:
  - Default W/ADDR/N constants.
  - `sample_t` typedef (logic [W-1:0]).
  - Function `tap_index(wr_ptr, k)`.
- Sub-module `fir_ring_ram`:
  - Simple dual-port RAM, NUM_CH*N × W.
  - Synchronous read-old-data on address collision.
  - No reset on the storage array.
- Top level holds the pointer/fill arrays, tap mask, output register and channel range checks.

## Test plan
- Reset, then read ch0 k=0..3 → `x_out`=0 for each, `rd_valid_out` one cycle after each request, `full_out`=0.
- Write ch0 12'h001..12'h005, then read k=0..4 → 5,4,3,2,1. Read k=5 → 0 (masked).
- Write N+3 samples of value i (mod 4096) to ch1 → `full_out[1]` rises on write N. k=0 reads N+2, k=N-1 reads 3 (wrap). ch0 is unaffected.
- With ch0 full, read k=N-1 and write 12'hABC in the same cycle → `x_out` is the old oldest sample. The next read at k=0 returns 12'hABC.
- Assert `clear_in` with a simultaneous write of 12'h777 → `full_out`=0. A read at k=0 returns 0. The write is not stored.
- Assert `rst_in` with a read in flight → `rd_valid_out` stays 0 and `x_out`=0 on the following cycle.
